// File: rtl/uart_driver.sv
// Full-duplex UART with a valid/ready byte interface, a stretched user reset and a forwarded user clock.
// Baud timing comes from per-direction bit counters of DIV = P_SYSTEM_CLK / P_UART_BUADRATE clocks.
module uart_driver #(
    parameter int P_SYSTEM_CLK      = 50000000,
    parameter int P_UART_BUADRATE   = 9600,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1,
    parameter int P_UART_CHECK      = 0,
    parameter int P_RST_CYCLE       = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_uart_rx,
    output logic                         o_uart_tx,
    input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
    input  logic                         i_user_tx_valid,
    output logic                         o_user_tx_ready,
    output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
    output logic                         o_user_rx_valid,
    output logic                         o_user_clk,
    output logic                         o_user_rst,
    output logic [2:0]                   o_tx_state_dbg,
    output logic [2:0]                   o_rx_state_dbg
);

    localparam int W     = P_UART_DATA_WIDTH;
    localparam int DIV   = P_SYSTEM_CLK / P_UART_BUADRATE;
    localparam int CNT_W = $clog2(DIV);
    localparam int RST_W = $clog2(P_RST_CYCLE + 1);

    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(DIV / 2 - 1);
    localparam logic [3:0]       DATA_LAST = 4'(W - 1);
    localparam logic [3:0]       STOP_LAST = 4'(P_UART_STOP_WIDTH - 1);
    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(P_RST_CYCLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // ---------------- user reset stretcher ----------------
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             user_rst_q, user_rst_d;

    always_comb begin
        rst_cnt_d  = rst_cnt_q;
        user_rst_d = user_rst_q;
        if (user_rst_q) begin
            if (rst_cnt_q == RST_LAST) user_rst_d = 1'b0;
            else                       rst_cnt_d  = rst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_cnt_q  <= '0;
            user_rst_q <= 1'b1;
        end else begin
            rst_cnt_q  <= rst_cnt_d;
            user_rst_q <= user_rst_d;
        end
    end

    // ---------------- transmitter ----------------
    // Handshake: a byte transfers on any rising edge where i_user_tx_valid and o_user_tx_ready
    // are both high; ready is a pure function of state, so valid never combinationally feeds it.
    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_idx_q, tx_idx_d;
    logic [W-1:0]     tx_shift_q, tx_shift_d;
    logic             tx_par_q, tx_par_d;
    logic             tx_line;
    logic             tx_ready;
    logic             tx_tick;

    assign tx_ready = (tx_state_q == ST_IDLE) && !user_rst_q;
    assign tx_tick  = (tx_cnt_q == BIT_END);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line    = 1'b1;
        if (tx_state_q != ST_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
        case (tx_state_q)
            ST_IDLE: begin
                if (i_user_tx_valid && tx_ready) begin
                    tx_shift_d = i_user_tx_data;
                    tx_par_d   = (P_UART_CHECK == 1) ? ~(^i_user_tx_data) : ^i_user_tx_data;
                    tx_cnt_d   = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                tx_line = 1'b0;
                if (tx_tick) begin
                    tx_idx_d   = '0;
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_line = tx_shift_q[0];
                if (tx_tick) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_idx_q == DATA_LAST) begin
                        tx_idx_d   = '0;
                        tx_state_d = (P_UART_CHECK != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                tx_line = tx_par_q;
                if (tx_tick) tx_state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tx_tick) begin
                    if (tx_idx_q == STOP_LAST) tx_state_d = ST_IDLE;
                    else                       tx_idx_d   = tx_idx_q + 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
        end
    end

    // ---------------- receiver ----------------
    uart_state_e      rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]       rx_idx_q, rx_idx_d;
    logic [W-1:0]     rx_shift_q, rx_shift_d;
    logic             rx_par_q, rx_par_d;
    logic [W-1:0]     rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic             rx_tick, rx_half, rx_par_ok;

    assign rx_tick = (rx_cnt_q == BIT_END);
    assign rx_half = (rx_cnt_q == HALF_END);

    always_comb begin
        case (P_UART_CHECK)
            1:       rx_par_ok = ^{rx_shift_q, rx_par_q};
            2:       rx_par_ok = ~(^{rx_shift_q, rx_par_q});
            default: rx_par_ok = 1'b1;
        endcase
    end

    // Counter restarts at every sample point so all later samples land one DIV apart from the start-bit centre.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!user_rst_q && rx_prev_q && !rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_half) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
                if (rx_tick) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[W-1:1]};
                    if (rx_idx_q == DATA_LAST) rx_state_d = (P_UART_CHECK != 0) ? ST_PARITY : ST_STOP;
                    else                       rx_idx_d   = rx_idx_q + 1'b1;
                end
            end
            ST_PARITY: begin
                rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
                if (rx_tick) begin
                    rx_par_d   = rx_sync_q;
                    rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
                if (rx_tick) begin
                    rx_state_d = ST_IDLE;
                    if (rx_sync_q && rx_par_ok) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_meta_q  <= i_uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign o_uart_tx       = tx_line;
    assign o_user_tx_ready = tx_ready;
    assign o_user_rx_data  = rx_data_q;
    assign o_user_rx_valid = rx_valid_q;
    assign o_user_clk      = clock;
    assign o_user_rst      = user_rst_q;
    assign o_tx_state_dbg  = tx_state_q;
    assign o_rx_state_dbg  = rx_state_q;

endmodule

// File: tb/tb_uart_driver.sv
// Bench for uart_driver: three instances (8N1 at DIV=86, even parity at DIV=16, odd parity 2-stop loopback at DIV=8).
// Received bytes are checked against per-instance expected queues filled when stimulus is driven.
module tb_uart_driver;

    localparam int DIV_A = 86;
    localparam int DIV_B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];
    logic [7:0] exp_q_c[$];
    logic [7:0] e_a, e_b, e_c;
    int         pulses_a = 0;
    int         pulses_c = 0;

    // instance A
    logic       rx_a_drv, tx_a, ready_a, valid_a, rx_valid_a, user_clk_a, user_rst_a;
    logic [7:0] tx_data_a, rx_data_a;
    logic [2:0] tx_dbg_a, rx_dbg_a;
    // instance B
    logic       rx_b_drv, tx_b, ready_b, rx_valid_b, user_clk_b, user_rst_b;
    logic [7:0] rx_data_b;
    logic [2:0] tx_dbg_b, rx_dbg_b;
    // instance C (loopback)
    logic       tx_c, ready_c, valid_c, rx_valid_c, user_clk_c, user_rst_c;
    logic [7:0] tx_data_c, rx_data_c;
    logic [2:0] tx_dbg_c, rx_dbg_c;

    uart_driver #(.P_SYSTEM_CLK(100000000), .P_UART_BUADRATE(1152000)) u_a (
        .clock(clk), .reset(rst_n), .i_uart_rx(rx_a_drv), .o_uart_tx(tx_a),
        .i_user_tx_data(tx_data_a), .i_user_tx_valid(valid_a), .o_user_tx_ready(ready_a),
        .o_user_rx_data(rx_data_a), .o_user_rx_valid(rx_valid_a),
        .o_user_clk(user_clk_a), .o_user_rst(user_rst_a),
        .o_tx_state_dbg(tx_dbg_a), .o_rx_state_dbg(rx_dbg_a)
    );

    uart_driver #(.P_SYSTEM_CLK(1600), .P_UART_BUADRATE(100), .P_UART_CHECK(2)) u_b (
        .clock(clk), .reset(rst_n), .i_uart_rx(rx_b_drv), .o_uart_tx(tx_b),
        .i_user_tx_data(8'h00), .i_user_tx_valid(1'b0), .o_user_tx_ready(ready_b),
        .o_user_rx_data(rx_data_b), .o_user_rx_valid(rx_valid_b),
        .o_user_clk(user_clk_b), .o_user_rst(user_rst_b),
        .o_tx_state_dbg(tx_dbg_b), .o_rx_state_dbg(rx_dbg_b)
    );

    uart_driver #(.P_SYSTEM_CLK(800), .P_UART_BUADRATE(100), .P_UART_CHECK(1), .P_UART_STOP_WIDTH(2)) u_c (
        .clock(clk), .reset(rst_n), .i_uart_rx(tx_c), .o_uart_tx(tx_c),
        .i_user_tx_data(tx_data_c), .i_user_tx_valid(valid_c), .o_user_tx_ready(ready_c),
        .o_user_rx_data(rx_data_c), .o_user_rx_valid(rx_valid_c),
        .o_user_clk(user_clk_c), .o_user_rst(user_rst_c),
        .o_tx_state_dbg(tx_dbg_c), .o_rx_state_dbg(rx_dbg_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (rx_valid_a) begin
            pulses_a++;
            check("rx_a_pending", 32'(exp_q_a.size() > 0), 1);
            if (exp_q_a.size() > 0) begin
                e_a = exp_q_a.pop_front();
                check("rx_a_data", rx_data_a, e_a);
            end
        end
        if (rx_valid_b) begin
            check("rx_b_pending", 32'(exp_q_b.size() > 0), 1);
            if (exp_q_b.size() > 0) begin
                e_b = exp_q_b.pop_front();
                check("rx_b_data", rx_data_b, e_b);
            end
        end
        if (rx_valid_c) begin
            pulses_c++;
            check("rx_c_pending", 32'(exp_q_c.size() > 0), 1);
            if (exp_q_c.size() > 0) begin
                e_c = exp_q_c.pop_front();
                check("rx_c_data", rx_data_c, e_c);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic ready_of(input int sel);
        return (sel == 0) ? ready_a : ready_c;
    endfunction

    // Returns #1 after the handshake edge, i.e. in the first cycle of the start bit.
    task automatic tx_send(input int sel, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!ready_of(sel) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("tx%0d_ready_wait", sel), 32'(n < 2000), 1);
        if (sel == 0) begin tx_data_a = d; valid_a = 1'b1; end
        else          begin tx_data_c = d; valid_c = 1'b1; end
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_c = 1'b0;
    endtask

    task automatic rx_drive(input int sel, input logic [15:0] bits, input int nb, input int div);
        @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            if (sel == 0) rx_a_drv = bits[i];
            else          rx_b_drv = bits[i];
            repeat (div) @(negedge clk);
        end
        rx_a_drv = 1'b1;
        rx_b_drv = 1'b1;
    endtask

    task automatic tx_frame_check_a(input string tag, input logic [7:0] d);
        logic [9:0] bits;
        int         errs[10];
        int         ready_low = 0;
        bits = {1'b1, d, 1'b0};
        for (int b = 0; b < 10; b++) errs[b] = 0;
        tx_send(0, d);
        for (int i = 0; i < 10 * DIV_A; i++) begin
            if (tx_a !== bits[i / DIV_A]) errs[i / DIV_A]++;
            if (!ready_a) ready_low++;
            @(posedge clk);
            #1;
        end
        for (int b = 0; b < 10; b++) check($sformatf("%s_bit%0d", tag, b), errs[b], 0);
        check({tag, "_ready_low"}, ready_low, 10 * DIV_A);
        check({tag, "_ready_back"}, ready_a, 1);
        check({tag, "_idle_tx"}, tx_a, 1);
    endtask

    task automatic wait_user_rst(input string tag, output int n);
        int bad = 0;
        n = 0;
        while (user_rst_a && n < 100) begin
            if (!tx_a || ready_a) bad++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_idle_during"}, bad, 0);
        check({tag, "_ready_after"}, ready_a, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst_n     = 1'b0;
        valid_a   = 1'b0;
        valid_c   = 1'b0;
        tx_data_a = 8'h00;
        tx_data_c = 8'h00;
        rx_a_drv  = 1'b1;
        rx_b_drv  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_ready", ready_a, 0);
        check("rst_rx_valid", rx_valid_a, 0);
        check("rst_rx_data", rx_data_a, 0);
        check("rst_user_rst", user_rst_a, 1);
        check("rst_tx_state", tx_dbg_a, 0);
        check("rst_rx_state", rx_dbg_a, 0);
        check("user_clk_lo", user_clk_a, clk);
        @(posedge clk);
        #1;
        check("user_clk_hi", user_clk_a, clk);

        @(negedge clk);
        rst_n = 1'b1;
        wait_user_rst("urst", n);
        check("urst_len", n, 10);
        check("urst_b", user_rst_b, 0);

        tx_frame_check_a("tx55", 8'h55);

        for (int v = 0; v < 256; v++) begin
            exp_q_c.push_back(8'(v));
            tx_send(2, 8'(v));
        end
        n = 0;
        while (exp_q_c.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("loop_drained", exp_q_c.size(), 0);
        check("loop_count", pulses_c, 256);

        exp_q_b.push_back(8'h07);
        rx_drive(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, DIV_B);
        repeat (3 * DIV_B) @(negedge clk);
        check("par_good_seen", exp_q_b.size(), 0);
        check("par_good_data", rx_data_b, 8'h07);
        rx_drive(1, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, DIV_B);
        repeat (3 * DIV_B) @(negedge clk);
        check("par_bad_kept", rx_data_b, 8'h07);
        rx_drive(1, 16'({1'b0, 1'b1, 8'h07, 1'b0}), 11, DIV_B);
        repeat (3 * DIV_B) @(negedge clk);
        check("stop_bad_kept", rx_data_b, 8'h07);
        exp_q_b.push_back(8'h5A);
        rx_drive(1, 16'({1'b1, 1'b0, 8'h5A, 1'b0}), 11, DIV_B);
        repeat (3 * DIV_B) @(negedge clk);
        check("par_next_seen", exp_q_b.size(), 0);
        check("par_next_data", rx_data_b, 8'h5A);

        n = pulses_a;
        @(negedge clk);
        rx_a_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx_a_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_pulses", pulses_a - n, 0);
        check("glitch_rx_idle", rx_dbg_a, 0);
        exp_q_a.push_back(8'hA3);
        rx_drive(0, 16'({1'b1, 8'hA3, 1'b0}), 10, DIV_A);
        repeat (3 * DIV_A) @(negedge clk);
        check("rx_a3_seen", exp_q_a.size(), 0);
        check("rx_a3_data", rx_data_a, 8'hA3);

        tx_send(0, 8'h00);
        repeat (5 * DIV_A + 40) @(posedge clk);
        #1;
        check("mid_tx_low", tx_a, 0);
        check("mid_tx_state", tx_dbg_a, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx_a, 1);
        check("mid_rst_ready", ready_a, 0);
        check("mid_rst_urst", user_rst_a, 1);
        check("mid_rst_state", tx_dbg_a, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        wait_user_rst("urst2", n);
        check("urst2_len", n, 10);
        tx_frame_check_a("tx3c", 8'h3C);

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached (tests run %0d)", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
